// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed digit scanner for a DIGITS x SEGW segment display.
// A write-port buffer holds one raw pattern per digit; a prescaler tick walks
// each digit slot through 16 phases (blank, lit, dark) to set brightness.
module seg_scan_ctrl #(
    parameter int DIGITS = 10,
    parameter int SEGW   = 8,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [DIV_W-1:0]  div,
    input  logic [3:0]        bright,
    input  logic              wr_en,
    input  logic [3:0]        wr_addr,
    input  logic [SEGW-1:0]   wr_data,
    output logic [DIGITS-1:0] sel,
    output logic [SEGW-1:0]   segm,
    output logic              frame_done
);

    localparam int            AW   = $clog2(DIGITS);
    localparam logic [AW-1:0] LAST = AW'(DIGITS - 1);

    typedef enum logic [1:0] {IDLE, BLANK, ON, DARK} state_t;

    logic [SEGW-1:0]  seg_buf [DIGITS];
    state_t           state, nstate;
    logic [3:0]       phase, nphase, phase_inc;
    logic [AW-1:0]    digit, ndigit;
    logic [DIV_W-1:0] count, ncount;
    logic             tick, wrap;

    // Pattern buffer: accepts writes in every state, out-of-range addresses dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: this buffer is reset on purpose so a restarted scan never shows stale patterns.
            seg_buf <= '{default: '0};
        end else if (wr_en && ({28'd0, wr_addr} < 32'(DIGITS))) begin
            seg_buf[wr_addr[AW-1:0]] <= wr_data;
        end
    end

    // Next-state logic: prescaler, phase sequencing and slot advance.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        nstate    = state;
        nphase    = phase;
        ndigit    = digit;
        ncount    = count;
        wrap      = 1'b0;
        tick      = (count == div);
        phase_inc = phase + 4'd1;
        if (!enable) begin
            nstate = IDLE;
            nphase = '0;
            ndigit = '0;
            ncount = '0;
        end else if (state == IDLE) begin
            nstate = BLANK;
            nphase = '0;
            ndigit = '0;
            ncount = '0;
        end else begin
            // A count above a lowered div simply runs on to the all-ones wrap.
            ncount = tick ? '0 : count + DIV_W'(1);
            if (tick) begin
                if (phase == 4'd15) begin
                    nphase = '0;
                    nstate = BLANK;
                    if (digit == LAST) begin
                        ndigit = '0;
                        wrap   = 1'b1;
                    end else begin
                        ndigit = digit + AW'(1);
                    end
                end else begin
                    nphase = phase_inc;
                    nstate = (phase_inc <= bright) ? ON : DARK;
                end
            end
        end
    end

    // State registers plus outputs registered from the next-state values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            phase      <= '0;
            digit      <= '0;
            count      <= '0;
            sel        <= '0;
            segm       <= '0;
            frame_done <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state      <= nstate;
            phase      <= nphase;
            digit      <= ndigit;
            count      <= ncount;
            sel        <= (nstate == ON) ? (DIGITS'(1) << ndigit) : '0;
            segm       <= (nstate == ON) ? seg_buf[ndigit] : '0;
            frame_done <= wrap;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench for seg_scan_ctrl. Expected per-cycle
// sel/segm/frame_done values are queued as stimulus is set up and popped on
// every falling edge.
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] div;
    logic [3:0]  bright;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [9:0]  sel;
    logic [7:0]  segm;
    logic        frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [9:0] sel;
        logic [7:0] segm;
        logic       fd;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] model_buf [10];

    seg_scan_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .div        (div),
        .bright     (bright),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .sel        (sel),
        .segm       (segm),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic push_cycles(input int n, input logic [9:0] s, input logic [7:0] g, input logic fd_first);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.sel  = s;
            e.segm = g;
            e.fd   = (i == 0) ? fd_first : 1'b0;
            sb.push_back(e);
        end
    endtask

    // One digit slot: blank phase, bright lit phases, remaining dark phases.
    task automatic push_slot(input int d, input int dv, input int br, input logic fd_first);
        push_cycles(dv + 1, 10'd0, 8'd0, fd_first);
        push_cycles(br * (dv + 1), 10'd1 << d, model_buf[d], 1'b0);
        push_cycles((15 - br) * (dv + 1), 10'd0, 8'd0, 1'b0);
    endtask

    task automatic push_frame(input int dv, input int br, input logic fd_first);
        for (int d = 0; d < 10; d++) push_slot(d, dv, br, (d == 0) && fd_first);
    endtask

    task automatic drain_one();
        exp_t e;
        @(negedge clk);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check("sel", 32'(sel), 32'(e.sel));
        check("segm", 32'(segm), 32'(e.segm));
        check("frame_done", 32'(frame_done), 32'(e.fd));
    endtask

    task automatic drain();
        while (sb.size() > 0) drain_one();
    endtask

    task automatic do_write(input logic [3:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        if (a < 4'd10) model_buf[a] = d;
    endtask

    initial begin
        int n;
        rst = 1'b1; enable = 1'b0; div = 16'd0; bright = 4'd15;
        wr_en = 1'b0; wr_addr = 4'd0; wr_data = 8'd0;
        for (int i = 0; i < 10; i++) model_buf[i] = 8'd0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_segm", 32'(segm), 32'd0);
        check("rst_fd", 32'(frame_done), 32'd0);
        rst = 1'b0;

        // Load the buffer while idle; display must stay dark.
        for (int i = 0; i < 10; i++) do_write(4'(i), 8'h10 + 8'(i));
        push_cycles(2, 10'd0, 8'd0, 1'b0);
        drain();

        // Basic scan, div=0, bright=15, then stop in the middle of digit 6 lit.
        enable = 1'b1;
        push_frame(0, 15, 1'b0);
        push_frame(0, 15, 1'b1);
        for (int d = 0; d < 6; d++) push_slot(d, 0, 15, d == 0);
        push_cycles(1, 10'd0, 8'd0, 1'b0);
        push_cycles(5, 10'd1 << 6, model_buf[6], 1'b0);
        drain();

        // Enable drop: dark immediately, no frame_done.
        enable = 1'b0;
        push_cycles(5, 10'd0, 8'd0, 1'b0);
        drain();

        // Re-enable with div=3, bright=4: restart at digit 0 blank; stop with digit 3 lit.
        div = 16'd3; bright = 4'd4; enable = 1'b1;
        push_frame(3, 4, 1'b0);
        for (int d = 0; d < 3; d++) push_slot(d, 3, 4, d == 0);
        push_cycles(4, 10'd0, 8'd0, 1'b0);
        push_cycles(4, 10'd1 << 3, model_buf[3], 1'b0);
        drain();

        // Live write to the lit digit: segm follows two edges after wr_en is sampled.
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'hFF;
        push_cycles(1, 10'd1 << 3, model_buf[3], 1'b0);
        drain_one();
        wr_en = 1'b0;
        model_buf[3] = 8'hFF;
        push_cycles(11, 10'd1 << 3, 8'hFF, 1'b0);
        push_cycles(44, 10'd0, 8'd0, 1'b0);
        for (int d = 4; d < 10; d++) push_slot(d, 3, 4, 1'b0);
        drain();

        // Out-of-range write: the following frame must be unchanged.
        wr_en = 1'b1; wr_addr = 4'd12; wr_data = 8'hAA;
        push_frame(3, 4, 1'b1);
        drain_one();
        wr_en = 1'b0;
        drain();

        // bright=0: dark for a whole frame.
        bright = 4'd0;
        push_frame(3, 0, 1'b1);
        push_cycles(1, 10'd0, 8'd0, 1'b1);
        drain();

        // Back to bright=4 and run up to digit 2 lit, then reset asynchronously.
        bright = 4'd4;
        push_cycles(3, 10'd0, 8'd0, 1'b0);
        push_cycles(16, 10'd1, model_buf[0], 1'b0);
        push_cycles(44, 10'd0, 8'd0, 1'b0);
        push_slot(1, 3, 4, 1'b0);
        push_cycles(4, 10'd0, 8'd0, 1'b0);
        push_cycles(5, 10'h004, model_buf[2], 1'b0);
        drain();
        #2 rst = 1'b1;
        #1;
        check("async_rst_sel", 32'(sel), 32'd0);
        check("async_rst_segm", 32'(segm), 32'd0);
        check("async_rst_fd", 32'(frame_done), 32'd0);
        for (int i = 0; i < 10; i++) model_buf[i] = 8'd0;
        @(negedge clk);
        rst = 1'b0; div = 16'd0; bright = 4'd15;
        push_frame(0, 15, 1'b0);
        push_cycles(1, 10'd0, 8'd0, 1'b1);
        drain();

        // div=1: every phase lasts two cycles.
        enable = 1'b0;
        push_cycles(2, 10'd0, 8'd0, 1'b0);
        drain();
        div = 16'd1; enable = 1'b1;
        push_frame(1, 15, 1'b0);
        push_cycles(1, 10'd0, 8'd0, 1'b1);
        drain();

        // div=16'hFFFF: measure the blank-to-lit tick interval.
        enable = 1'b0;
        push_cycles(1, 10'd0, 8'd0, 1'b0);
        drain();
        div = 16'hFFFF; enable = 1'b1;
        @(posedge clk);
        n = 0;
        while (n < 70000) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (sel != 10'd0) break;
        end
        check("tick_interval", 32'(n), 32'd65536);
        check("max_div_sel", 32'(sel), 32'h001);
        check("max_div_segm", 32'(segm), 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Multiplexed scan controller for the 10-digit, 8-segment display driven on sel/segm (io_out[19:10] / io_out[27:20]).
- Holds one raw segment pattern per digit in a write-port buffer and cycles through the digits using a programmable prescaler.
- Provides per-slot dead-time blanking and a 16-level brightness duty.
- Sits between the posoco2000 datapath (pattern writer) and the pads.

Parameters:
- DIGITS, 10, number of digit positions (sel width); 2..16.
- SEGW, 8, segment bits per digit (7 segments + dp).
- DIV_W, 16, prescaler width.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- enable  input  1  scan enable; 0 = display dark and scanner held
- div  input  DIV_W  tick period minus 1 (tick every div+1 clk cycles)
- bright  input  4  on-phases per digit slot (0 = dark, 15 = max)
- wr_en  input  1  buffer write strobe, one cycle
- wr_addr  input  4  digit index to write
- wr_data  input  SEGW  raw segment pattern, bit=1 lights segment
- sel  output  DIGITS  one-hot digit select, active-high, registered
- segm  output  SEGW  segment drive, active-high, registered
- frame_done  output  1  one-cycle pulse at end of last digit slot

Behaviour:
- Reset (async, rst=1):
  - buffer all zero; sel=0, segm=0, frame_done=0.
  - digit index=0, phase=0, prescaler=0, state IDLE.
- Prescaler:
  - Counts 0..div; tick asserted on the cycle count==div, then the count returns to 0.
  - div=0 gives a tick every cycle.
  - div is sampled live; if div is lowered below the current count, the counter continues to all-ones wrap before ticking. No special-casing.
- States:
  - IDLE: enable=0. Outputs 0; prescaler, phase and digit held at 0. enable=1 -> BLANK at the next edge, digit 0, phase 0.
  - BLANK (phase 0): sel=0, segm=0. On tick: phase=1, -> ON if bright>=1, else -> DARK.
  - ON (phase 1..bright): sel=one-hot(digit), segm=buf[digit]. On tick: phase+1; when phase reaches bright+1 (and <=15) -> DARK.
  - DARK (phase bright+1..15): outputs 0. The tick at phase 15 advances the slot.
  - bright=15: ON directly to slot advance at the phase-15 tick.
- Slot advance (tick at phase 15):
  - digit = digit+1, wrapping DIGITS-1 -> 0; phase=0; -> BLANK.
  - On the wrap, frame_done=1 for exactly that one cycle.
- Slot timing: 16 ticks per slot, 16*DIGITS ticks per frame.
- bright is sampled at each phase transition; a change takes effect within the current slot from the next tick.
- enable=0 at any time: next edge -> IDLE, outputs 0, no frame_done. Buffer contents are retained.
- Output timing: sel/segm are registered from the next-state values, so they change on the same edge as the state and phase.
- Writes:
  - wr_en with wr_addr<DIGITS updates buf[wr_addr] at that edge.
  - wr_addr>=DIGITS is ignored with no side effects.
  - A write to the currently lit digit appears on segm one edge after the buffer updates (2 edges after wr_en is sampled).
  - Writes are accepted in all states, including IDLE.
- Simultaneous events:
  - A write and a slot advance in the same cycle: the write lands and the scan proceeds normally.
  - A rst mid-slot clears everything immediately, asynchronously.

Test Plan:
- Reset check: rst=1 mid-scan, with sel=10'h004 lit -> sel=0, segm=0 and the buffer reads back 0 (segm stays 0 on every digit after restart).
- Basic scan: div=0, bright=15, buf[i]=8'h10+i, enable=1.
  - Per digit: 1 blank cycle, then 15 cycles with sel=1<<i and segm=8'h10+i.
  - frame_done pulses once every 160 cycles, on the cycle after digit 9 ends.
- Brightness: div=3, bright=4.
  - Each slot: 4 clk blank, 16 clk lit, 44 clk dark.
  - bright=0: sel stays 0 for an entire frame.
- Live write and bad address:
  - While digit 3 is lit, write addr 3 = 8'hFF -> segm=8'hFF 2 edges later.
  - Write addr 12 -> no buffer change over the following frame.
- Enable drop: enable=0 during digit 6 ON -> outputs 0 at the next edge and no frame_done. Re-enable -> scan restarts at digit 0 with the blank phase.
- Prescaler edge: div=16'hFFFF with the tick interval measured -> 65536 clk cycles. div=1 -> a tick every 2 cycles.
